// File: rtl/alu_status_stage_if.sv
// ALU result handshake bundle between the ALU units, the status stage and the
// downstream consumer.
//   in_valid / in_ready      upstream result handshake
//   in_result                ALU result (size bits)
//   in_flags_n_z_v_c         ALU flags [3]=N [2]=Z [1]=V [0]=C
//   in_set_flags             commit this result's flags when it retires
//   out_valid / out_ready    downstream head-entry handshake
//   out_result               head entry result
// master: the side that produces results and consumes the head entry.
// slave:  the status stage itself.
interface alu_status_stage_if #(
    parameter int unsigned size = 4
) ();
    logic            in_valid;
    logic            in_ready;
    logic [size-1:0] in_result;
    logic [3:0]      in_flags_n_z_v_c;
    logic            in_set_flags;
    logic            out_valid;
    logic            out_ready;
    logic [size-1:0] out_result;

    modport master (
        output in_valid,
        output in_result,
        output in_flags_n_z_v_c,
        output in_set_flags,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result
    );

    modport slave (
        input  in_valid,
        input  in_result,
        input  in_flags_n_z_v_c,
        input  in_set_flags,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result
    );
endinterface

// File: rtl/alu_status_stage.sv
// Registered stage behind the ALU units. Buffers up to two {result, flags,
// set_flags} entries in a skid FIFO and, as each entry retires, optionally
// commits its flags into the architectural status register. A combinational
// condition-code evaluator runs off the committed flags.
// Ports:
//   clk              single clock, rising edge
//   reset_n          asynchronous active-low reset
//   bus              result handshake (slave modport), see alu_status_stage_if
//   flush            synchronous discard of all buffered entries
//   cond_code        condition to evaluate (EQ..NV)
//   status_n_z_v_c   committed status register [3]=N [2]=Z [1]=V [0]=C
//   cond_true        cond_code satisfied by status_n_z_v_c
module alu_status_stage #(
    parameter int unsigned size = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    alu_status_stage_if.slave    bus,
    input  logic                 flush,
    input  logic [3:0]           cond_code,
    output logic [3:0]           status_n_z_v_c,
    output logic                 cond_true
);

    logic [size-1:0] result_q [2];
    logic [3:0]      flags_q  [2];
    logic [1:0]      set_q;

    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [3:0] status_q, status_d;

    logic push, pop, accept;

    // Handshake outputs depend on registered occupancy only.
    assign bus.in_ready   = (count_q != 2'd2);
    assign bus.out_valid  = (count_q != 2'd0);
    assign bus.out_result = bus.out_valid ? result_q[rd_ptr_q] : '0;
    assign status_n_z_v_c = status_q;

    always_comb begin
        push   = bus.in_valid && bus.in_ready;
        pop    = bus.out_valid && bus.out_ready;
        // A push coinciding with flush is dropped; the pop still retires.
        accept = push && !flush;

        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else if (accept && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!accept && pop) begin
            count_d = count_q - 2'd1;
        end

        wr_ptr_d = flush ? 1'b0 : (wr_ptr_q ^ accept);
        rd_ptr_d = flush ? 1'b0 : (rd_ptr_q ^ pop);

        status_d = status_q;
        if (pop && set_q[rd_ptr_q]) begin
            status_d = flags_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            status_q <= 4'b0000;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            status_q <= status_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                result_q[i] <= '0;
                flags_q[i]  <= 4'b0000;
            end
            set_q <= 2'b00;
        end else if (accept) begin
            result_q[wr_ptr_q] <= bus.in_result;
            flags_q[wr_ptr_q]  <= bus.in_flags_n_z_v_c;
            set_q[wr_ptr_q]    <= bus.in_set_flags;
        end
    end

    // Condition-code evaluation on committed flags.
    logic flag_n, flag_z, flag_v, flag_c;
    assign {flag_n, flag_z, flag_v, flag_c} = status_q;

    always_comb begin
        cond_true = 1'b0;
        unique case (cond_code)
            4'd0:  cond_true = flag_z;
            4'd1:  cond_true = !flag_z;
            4'd2:  cond_true = flag_c;
            4'd3:  cond_true = !flag_c;
            4'd4:  cond_true = flag_n;
            4'd5:  cond_true = !flag_n;
            4'd6:  cond_true = flag_v;
            4'd7:  cond_true = !flag_v;
            4'd8:  cond_true = flag_c && !flag_z;
            4'd9:  cond_true = !flag_c || flag_z;
            4'd10: cond_true = (flag_n == flag_v);
            4'd11: cond_true = (flag_n != flag_v);
            4'd12: cond_true = !flag_z && (flag_n == flag_v);
            4'd13: cond_true = flag_z || (flag_n != flag_v);
            4'd14: cond_true = 1'b1;
            4'd15: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule
